// File: rtl/mips_pipe_ctrl.sv
// mips_pipe_ctrl: control unit for a five-stage (F/D/E/M/W) MIPS pipeline.
// Decodes the D-stage instruction, carries E/M/W control fields in
// pipeline registers and resolves data hazards with Tuse/Tnew stalls and
// forwarding selects (or stall-only operation when ENABLE_FWD = 0).
module mips_pipe_ctrl #(
    parameter int unsigned REG_AW     = 5,
    parameter bit          ENABLE_FWD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_d,
    input  logic              cmp_eq,
    output logic              stall,
    output logic [1:0]        npc_sel,
    output logic              ext_op,
    output logic              alu_src_e,
    output logic [1:0]        alu_op_e,
    output logic              mem_write_m,
    output logic              reg_write_w,
    output logic [1:0]        wd_sel_w,
    output logic [REG_AW-1:0] wa_w,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m
);

    // Opcode / function encodings
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Next-PC selects
    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    // Write-data selects
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC8 = 2'b10;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    // Forwarding selects (D stage uses all four, E stage the lower three)
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_E  = 2'b11;

    localparam logic [REG_AW-1:0] ZERO_REG = {REG_AW{1'b0}};
    localparam logic [REG_AW-1:0] LINK_REG = {REG_AW{1'b1}};

    // Tnew counts down one per stage and never goes below zero.
    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        logic [1:0] r;
        if (t == 2'd0) begin
            r = 2'd0;
        end else begin
            r = t - 2'd1;
        end
        return r;
    endfunction

    // A D source conflicts with a producer stage if it reads the register
    // being written; with forwarding only if the value is not ready in time.
    function automatic logic src_hazard(input logic [REG_AW-1:0] src,
                                        input logic [1:0]        tuse,
                                        input logic [REG_AW-1:0] wa,
                                        input logic [1:0]        tnew);
        logic hit;
        logic r;
        hit = (src != ZERO_REG) && (src == wa);
        if (ENABLE_FWD) begin
            r = hit && (tuse < tnew);
        end else begin
            r = hit;
        end
        return r;
    endfunction

    // D-stage forward source: youngest matching stage wins; a match whose
    // value is not yet produced blocks the older stages.
    function automatic logic [1:0] fwd_sel_d(input logic [REG_AW-1:0] src,
                                             input logic [REG_AW-1:0] wa_e,
                                             input logic [1:0]        tnew_e,
                                             input logic [REG_AW-1:0] wa_m,
                                             input logic [1:0]        tnew_m,
                                             input logic [REG_AW-1:0] wa_wb,
                                             input logic [1:0]        tnew_wb);
        logic [1:0] sel;
        if (src == ZERO_REG) begin
            sel = FWD_RF;
        end else if (src == wa_e) begin
            sel = (tnew_e == 2'd0) ? FWD_E : FWD_RF;
        end else if (src == wa_m) begin
            sel = (tnew_m == 2'd0) ? FWD_M : FWD_RF;
        end else if (src == wa_wb) begin
            sel = (tnew_wb == 2'd0) ? FWD_W : FWD_RF;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // E-stage forward source from the M and W producers.
    function automatic logic [1:0] fwd_sel_e(input logic [REG_AW-1:0] src,
                                             input logic [REG_AW-1:0] wa_m,
                                             input logic [1:0]        tnew_m,
                                             input logic [REG_AW-1:0] wa_wb,
                                             input logic [1:0]        tnew_wb);
        logic [1:0] sel;
        if (src == ZERO_REG) begin
            sel = FWD_RF;
        end else if (src == wa_m) begin
            sel = (tnew_m == 2'd0) ? FWD_M : FWD_RF;
        end else if (src == wa_wb) begin
            sel = (tnew_wb == 2'd0) ? FWD_W : FWD_RF;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Instruction fields
    logic [5:0]        op_s;
    logic [5:0]        func_s;
    logic [REG_AW-1:0] rs_f_s;
    logic [REG_AW-1:0] rt_f_s;
    logic [REG_AW-1:0] rd_f_s;
    logic              unused_shamt_s;

    assign op_s           = instr_d[31:26];
    assign func_s         = instr_d[5:0];
    assign rs_f_s         = REG_AW'(instr_d[25:21]);
    assign rt_f_s         = REG_AW'(instr_d[20:16]);
    assign rd_f_s         = REG_AW'(instr_d[15:11]);
    assign unused_shamt_s = ^instr_d[10:6];

    // Decoded D-stage controls
    logic              dec_rw_s;
    logic [REG_AW-1:0] dec_wa_s;
    logic [1:0]        dec_wd_s;
    logic              dec_alu_src_s;
    logic [1:0]        dec_alu_op_s;
    logic              dec_mw_s;
    logic [1:0]        dec_tnew_s;
    logic              use_rs_s;
    logic              use_rt_s;
    logic [1:0]        tuse_rs_s;
    logic [1:0]        tuse_rt_s;
    logic [1:0]        dec_npc_s;
    logic              dec_ext_s;
    logic [REG_AW-1:0] src_rs_s;
    logic [REG_AW-1:0] src_rt_s;

    // E stage registers
    logic              rw_e_q, rw_e_d;
    logic [REG_AW-1:0] wa_e_q, wa_e_d;
    logic [1:0]        wd_e_q, wd_e_d;
    logic              alu_src_e_q, alu_src_e_d;
    logic [1:0]        alu_op_e_q, alu_op_e_d;
    logic              mw_e_q, mw_e_d;
    logic [1:0]        tnew_e_q, tnew_e_d;
    logic [REG_AW-1:0] rs_e_q, rs_e_d;
    logic [REG_AW-1:0] rt_e_q, rt_e_d;

    // M stage registers
    logic              rw_m_q, rw_m_d;
    logic [REG_AW-1:0] wa_m_q, wa_m_d;
    logic [1:0]        wd_m_q, wd_m_d;
    logic              mw_m_q, mw_m_d;
    logic [1:0]        tnew_m_q, tnew_m_d;
    logic [REG_AW-1:0] rt_m_q, rt_m_d;

    // W stage registers
    logic              rw_w_q, rw_w_d;
    logic [REG_AW-1:0] wa_w_q, wa_w_d;
    logic [1:0]        wd_w_q, wd_w_d;
    logic [1:0]        tnew_w_q, tnew_w_d;

    // Hazard / select results
    logic       stall_s;
    logic [1:0] npc_sel_s;
    logic [1:0] fwd_rs_d_s;
    logic [1:0] fwd_rt_d_s;
    logic [1:0] fwd_rs_e_s;
    logic [1:0] fwd_rt_e_s;
    logic       fwd_rt_m_s;

    // Decode the D-stage instruction; unknown encodings stay a nop.
    always_comb begin
        dec_rw_s      = 1'b0;
        dec_wa_s      = ZERO_REG;
        dec_wd_s      = WD_ALU;
        dec_alu_src_s = 1'b0;
        dec_alu_op_s  = ALU_ADD;
        dec_mw_s      = 1'b0;
        dec_tnew_s    = 2'd0;
        use_rs_s      = 1'b0;
        use_rt_s      = 1'b0;
        tuse_rs_s     = 2'd0;
        tuse_rt_s     = 2'd0;
        dec_npc_s     = NPC_PC4;
        dec_ext_s     = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                case (func_s)
                    FN_ADDU: begin
                        dec_rw_s     = 1'b1;
                        dec_wa_s     = rd_f_s;
                        dec_alu_op_s = ALU_ADD;
                        dec_tnew_s   = 2'd1;
                        use_rs_s     = 1'b1;
                        use_rt_s     = 1'b1;
                        tuse_rs_s    = 2'd1;
                        tuse_rt_s    = 2'd1;
                    end
                    FN_SUBU: begin
                        dec_rw_s     = 1'b1;
                        dec_wa_s     = rd_f_s;
                        dec_alu_op_s = ALU_SUB;
                        dec_tnew_s   = 2'd1;
                        use_rs_s     = 1'b1;
                        use_rt_s     = 1'b1;
                        tuse_rs_s    = 2'd1;
                        tuse_rt_s    = 2'd1;
                    end
                    FN_JR: begin
                        use_rs_s  = 1'b1;
                        tuse_rs_s = 2'd0;
                        dec_npc_s = NPC_JR;
                    end
                    default: begin
                        dec_rw_s = 1'b0;
                    end
                endcase
            end
            OP_ORI: begin
                dec_rw_s      = 1'b1;
                dec_wa_s      = rt_f_s;
                dec_alu_src_s = 1'b1;
                dec_alu_op_s  = ALU_OR;
                dec_tnew_s    = 2'd1;
                use_rs_s      = 1'b1;
                tuse_rs_s     = 2'd1;
            end
            OP_LUI: begin
                dec_rw_s      = 1'b1;
                dec_wa_s      = rt_f_s;
                dec_alu_src_s = 1'b1;
                dec_alu_op_s  = ALU_LUI;
                dec_tnew_s    = 2'd1;
                use_rs_s      = 1'b1;
                tuse_rs_s     = 2'd1;
            end
            OP_LW: begin
                dec_rw_s      = 1'b1;
                dec_wa_s      = rt_f_s;
                dec_wd_s      = WD_MEM;
                dec_alu_src_s = 1'b1;
                dec_tnew_s    = 2'd2;
                use_rs_s      = 1'b1;
                tuse_rs_s     = 2'd1;
                dec_ext_s     = 1'b1;
            end
            OP_SW: begin
                dec_mw_s      = 1'b1;
                dec_alu_src_s = 1'b1;
                use_rs_s      = 1'b1;
                use_rt_s      = 1'b1;
                tuse_rs_s     = 2'd1;
                tuse_rt_s     = 2'd2;
                dec_ext_s     = 1'b1;
            end
            OP_BEQ: begin
                use_rs_s  = 1'b1;
                use_rt_s  = 1'b1;
                tuse_rs_s = 2'd0;
                tuse_rt_s = 2'd0;
                dec_npc_s = NPC_BR;
                dec_ext_s = 1'b1;
            end
            OP_J: begin
                dec_npc_s = NPC_J;
            end
            OP_JAL: begin
                dec_rw_s   = 1'b1;
                dec_wa_s   = LINK_REG;
                dec_wd_s   = WD_PC8;
                dec_tnew_s = 2'd0;
                dec_npc_s  = NPC_J;
            end
            default: begin
                dec_rw_s = 1'b0;
            end
        endcase
    end

    // Unused sources collapse to $0, which never matches a producer.
    assign src_rs_s = use_rs_s ? rs_f_s : ZERO_REG;
    assign src_rt_s = use_rt_s ? rt_f_s : ZERO_REG;

    // Stall detection against the E and M producers; W never stalls
    // because the register file is write-before-read.
    always_comb begin
        stall_s = src_hazard(src_rs_s, tuse_rs_s, wa_e_q, tnew_e_q)
                | src_hazard(src_rs_s, tuse_rs_s, wa_m_q, tnew_m_q)
                | src_hazard(src_rt_s, tuse_rt_s, wa_e_q, tnew_e_q)
                | src_hazard(src_rt_s, tuse_rt_s, wa_m_q, tnew_m_q);
    end

    // Next-PC select; a stall holds the PC regardless of the branch.
    always_comb begin
        npc_sel_s = NPC_PC4;
        if (stall_s) begin
            npc_sel_s = NPC_PC4;
        end else if (dec_npc_s == NPC_BR) begin
            npc_sel_s = cmp_eq ? NPC_BR : NPC_PC4;
        end else begin
            npc_sel_s = dec_npc_s;
        end
    end

    // Forwarding mux selects for D, E and M consumers.
    always_comb begin
        fwd_rs_d_s = FWD_RF;
        fwd_rt_d_s = FWD_RF;
        fwd_rs_e_s = FWD_RF;
        fwd_rt_e_s = FWD_RF;
        fwd_rt_m_s = 1'b0;
        if (ENABLE_FWD) begin
            fwd_rs_d_s = fwd_sel_d(src_rs_s, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q,
                                   wa_w_q, tnew_w_q);
            fwd_rt_d_s = fwd_sel_d(src_rt_s, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q,
                                   wa_w_q, tnew_w_q);
            fwd_rs_e_s = fwd_sel_e(rs_e_q, wa_m_q, tnew_m_q, wa_w_q, tnew_w_q);
            fwd_rt_e_s = fwd_sel_e(rt_e_q, wa_m_q, tnew_m_q, wa_w_q, tnew_w_q);
            fwd_rt_m_s = (rt_m_q != ZERO_REG) && (rt_m_q == wa_w_q)
                         && (tnew_w_q == 2'd0);
        end else begin
            fwd_rs_d_s = FWD_RF;
            fwd_rt_d_s = FWD_RF;
            fwd_rs_e_s = FWD_RF;
            fwd_rt_e_s = FWD_RF;
            fwd_rt_m_s = 1'b0;
        end
    end

    // Next E contents: decoded instruction, or a bubble while stalling.
    always_comb begin
        rw_e_d      = 1'b0;
        wa_e_d      = ZERO_REG;
        wd_e_d      = WD_ALU;
        alu_src_e_d = 1'b0;
        alu_op_e_d  = ALU_ADD;
        mw_e_d      = 1'b0;
        tnew_e_d    = 2'd0;
        rs_e_d      = ZERO_REG;
        rt_e_d      = ZERO_REG;
        if (stall_s) begin
            rw_e_d = 1'b0;
        end else begin
            rw_e_d      = dec_rw_s;
            wa_e_d      = dec_wa_s;
            wd_e_d      = dec_wd_s;
            alu_src_e_d = dec_alu_src_s;
            alu_op_e_d  = dec_alu_op_s;
            mw_e_d      = dec_mw_s;
            tnew_e_d    = dec_tnew_s;
            rs_e_d      = src_rs_s;
            rt_e_d      = src_rt_s;
        end
    end

    // Advance E->M and M->W with Tnew counting down.
    always_comb begin
        rw_m_d   = rw_e_q;
        wa_m_d   = wa_e_q;
        wd_m_d   = wd_e_q;
        mw_m_d   = mw_e_q;
        tnew_m_d = sat_dec(tnew_e_q);
        rt_m_d   = rt_e_q;
        rw_w_d   = rw_m_q;
        wa_w_d   = wa_m_q;
        wd_w_d   = wd_m_q;
        tnew_w_d = sat_dec(tnew_m_q);
    end

    // Pipeline control registers; reset empties every stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rw_e_q      <= 1'b0;
            wa_e_q      <= ZERO_REG;
            wd_e_q      <= WD_ALU;
            alu_src_e_q <= 1'b0;
            alu_op_e_q  <= ALU_ADD;
            mw_e_q      <= 1'b0;
            tnew_e_q    <= 2'd0;
            rs_e_q      <= ZERO_REG;
            rt_e_q      <= ZERO_REG;
            rw_m_q      <= 1'b0;
            wa_m_q      <= ZERO_REG;
            wd_m_q      <= WD_ALU;
            mw_m_q      <= 1'b0;
            tnew_m_q    <= 2'd0;
            rt_m_q      <= ZERO_REG;
            rw_w_q      <= 1'b0;
            wa_w_q      <= ZERO_REG;
            wd_w_q      <= WD_ALU;
            tnew_w_q    <= 2'd0;
        end else begin
            rw_e_q      <= rw_e_d;
            wa_e_q      <= wa_e_d;
            wd_e_q      <= wd_e_d;
            alu_src_e_q <= alu_src_e_d;
            alu_op_e_q  <= alu_op_e_d;
            mw_e_q      <= mw_e_d;
            tnew_e_q    <= tnew_e_d;
            rs_e_q      <= rs_e_d;
            rt_e_q      <= rt_e_d;
            rw_m_q      <= rw_m_d;
            wa_m_q      <= wa_m_d;
            wd_m_q      <= wd_m_d;
            mw_m_q      <= mw_m_d;
            tnew_m_q    <= tnew_m_d;
            rt_m_q      <= rt_m_d;
            rw_w_q      <= rw_w_d;
            wa_w_q      <= wa_w_d;
            wd_w_q      <= wd_w_d;
            tnew_w_q    <= tnew_w_d;
        end
    end

    assign stall       = stall_s;
    assign npc_sel     = npc_sel_s;
    assign ext_op      = dec_ext_s;
    assign fwd_rs_d    = fwd_rs_d_s;
    assign fwd_rt_d    = fwd_rt_d_s;
    assign fwd_rs_e    = fwd_rs_e_s;
    assign fwd_rt_e    = fwd_rt_e_s;
    assign fwd_rt_m    = fwd_rt_m_s;
    assign alu_src_e   = alu_src_e_q;
    assign alu_op_e    = alu_op_e_q;
    assign mem_write_m = mw_m_q;
    assign reg_write_w = rw_w_q;
    assign wd_sel_w    = wd_w_q;
    assign wa_w        = wa_w_q;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// tb_mips_pipe_ctrl: drives a forwarding and a stall-only instance with
// directed and random instruction streams and compares every output each
// cycle against a stage-list reference model.
module tb_mips_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_v [2];
    logic        cmp_v   [2];

    logic        stall_o  [2];
    logic [1:0]  npc_o    [2];
    logic        ext_o    [2];
    logic        asrc_o   [2];
    logic [1:0]  aop_o    [2];
    logic        mw_o     [2];
    logic        rw_o     [2];
    logic [1:0]  wd_o     [2];
    logic [4:0]  wa_o     [2];
    logic [1:0]  frs_d_o  [2];
    logic [1:0]  frt_d_o  [2];
    logic [1:0]  frs_e_o  [2];
    logic [1:0]  frt_e_o  [2];
    logic        frt_m_o  [2];

    initial forever #5 clk = ~clk;

    mips_pipe_ctrl #(.REG_AW(5), .ENABLE_FWD(1'b1)) u_fwd (
        .clk(clk), .reset(reset), .instr_d(instr_v[0]), .cmp_eq(cmp_v[0]),
        .stall(stall_o[0]), .npc_sel(npc_o[0]), .ext_op(ext_o[0]),
        .alu_src_e(asrc_o[0]), .alu_op_e(aop_o[0]), .mem_write_m(mw_o[0]),
        .reg_write_w(rw_o[0]), .wd_sel_w(wd_o[0]), .wa_w(wa_o[0]),
        .fwd_rs_d(frs_d_o[0]), .fwd_rt_d(frt_d_o[0]),
        .fwd_rs_e(frs_e_o[0]), .fwd_rt_e(frt_e_o[0]), .fwd_rt_m(frt_m_o[0])
    );

    mips_pipe_ctrl #(.REG_AW(5), .ENABLE_FWD(1'b0)) u_nofwd (
        .clk(clk), .reset(reset), .instr_d(instr_v[1]), .cmp_eq(cmp_v[1]),
        .stall(stall_o[1]), .npc_sel(npc_o[1]), .ext_op(ext_o[1]),
        .alu_src_e(asrc_o[1]), .alu_op_e(aop_o[1]), .mem_write_m(mw_o[1]),
        .reg_write_w(rw_o[1]), .wd_sel_w(wd_o[1]), .wa_w(wa_o[1]),
        .fwd_rs_d(frs_d_o[1]), .fwd_rt_d(frt_d_o[1]),
        .fwd_rs_e(frs_e_o[1]), .fwd_rt_e(frt_e_o[1]), .fwd_rt_m(frt_m_o[1])
    );

    // One in-flight instruction; tnew0 is its Tnew on entering E,
    // rs/rt hold only the sources it actually reads (else 0).
    typedef struct {
        bit       wr;
        bit [4:0] wa;
        bit [1:0] wd;
        bit       asrc;
        bit [1:0] aop;
        bit       mw;
        int       tnew0;
        bit [4:0] rs;
        bit [4:0] rt;
    } ins_t;

    ins_t st [2][3];   // [instance][0=E,1=M,2=W]
    ins_t nop_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int idx,
                             input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    function automatic int tnew_at(input ins_t x, input int k);
        int t;
        t = x.tnew0 - k;
        return (t > 0) ? t : 0;
    endfunction

    // Tuse of -1 marks an operand the instruction does not read.
    // npc_kind: 0 seq, 1 beq, 2 j/jal, 3 jr.
    function automatic void m_decode(input logic [31:0] ins, output ins_t d,
                                     output int tu_rs, output int tu_rt,
                                     output int npc_kind, output bit ext);
        bit [5:0] op;
        bit [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        d = '{default: 0};
        tu_rs = -1; tu_rt = -1; npc_kind = 0; ext = 1'b0;
        if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
            d.wr = 1'b1; d.wa = ins[15:11]; d.aop = (fn == 6'h23) ? 2'd1 : 2'd0;
            d.tnew0 = 1; tu_rs = 1; tu_rt = 1;
        end else if (op == 6'h00 && fn == 6'h08) begin
            tu_rs = 0; npc_kind = 3;
        end else if (op == 6'h0d || op == 6'h0f) begin
            d.wr = 1'b1; d.wa = ins[20:16]; d.asrc = 1'b1;
            d.aop = (op == 6'h0f) ? 2'd3 : 2'd2; d.tnew0 = 1; tu_rs = 1;
        end else if (op == 6'h23) begin
            d.wr = 1'b1; d.wa = ins[20:16]; d.wd = 2'd1; d.asrc = 1'b1;
            d.tnew0 = 2; tu_rs = 1; ext = 1'b1;
        end else if (op == 6'h2b) begin
            d.mw = 1'b1; d.asrc = 1'b1; tu_rs = 1; tu_rt = 2; ext = 1'b1;
        end else if (op == 6'h04) begin
            tu_rs = 0; tu_rt = 0; npc_kind = 1; ext = 1'b1;
        end else if (op == 6'h02) begin
            npc_kind = 2;
        end else if (op == 6'h03) begin
            d.wr = 1'b1; d.wa = 5'd31; d.wd = 2'd2; d.tnew0 = 0; npc_kind = 2;
        end
        d.rs = (tu_rs >= 0) ? ins[25:21] : 5'd0;
        d.rt = (tu_rt >= 0) ? ins[20:16] : 5'd0;
    endfunction

    // Predict and compare all outputs of instance i for the current cycle.
    task automatic model_cycle(input int i, output bit stl, output ins_t dec);
        ins_t d;
        int   tu_rs, tu_rt, nk, sel, exp_npc;
        bit   ext, found, fm;
        int   src [2];
        int   tu  [2];
        int   fd  [2];
        int   fe  [2];
        m_decode(instr_v[i], d, tu_rs, tu_rt, nk, ext);
        src[0] = d.rs; src[1] = d.rt; tu[0] = tu_rs; tu[1] = tu_rt;
        stl = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 2; k++)
                if (src[s] != 0 && st[i][k].wa == src[s])
                    if (i == 1 || tu[s] < tnew_at(st[i][k], k)) stl = 1'b1;
        exp_npc = stl ? 0 : (nk == 1) ? (cmp_v[i] ? 1 : 0) : nk;
        for (int s = 0; s < 2; s++) begin
            sel = 0; found = 1'b0;
            for (int k = 0; k < 3; k++)
                if (!found && src[s] != 0 && st[i][k].wa == src[s]) begin
                    found = 1'b1;
                    sel = (tnew_at(st[i][k], k) == 0) ? 3 - k : 0;
                end
            fd[s] = (i == 0) ? sel : 0;
        end
        src[0] = st[i][0].rs; src[1] = st[i][0].rt;
        for (int s = 0; s < 2; s++) begin
            sel = 0; found = 1'b0;
            for (int k = 1; k < 3; k++)
                if (!found && src[s] != 0 && st[i][k].wa == src[s]) begin
                    found = 1'b1;
                    sel = (tnew_at(st[i][k], k) == 0) ? 3 - k : 0;
                end
            fe[s] = (i == 0) ? sel : 0;
        end
        fm = (i == 0) && st[i][1].rt != 0 && st[i][1].rt == st[i][2].wa
             && tnew_at(st[i][2], 2) == 0;
        check_val("stall",       i, 32'(stall_o[i]), 32'(stl));
        check_val("npc_sel",     i, 32'(npc_o[i]),   32'(exp_npc));
        check_val("ext_op",      i, 32'(ext_o[i]),   32'(ext));
        check_val("alu_src_e",   i, 32'(asrc_o[i]),  32'(st[i][0].asrc));
        check_val("alu_op_e",    i, 32'(aop_o[i]),   32'(st[i][0].aop));
        check_val("mem_write_m", i, 32'(mw_o[i]),    32'(st[i][1].mw));
        check_val("reg_write_w", i, 32'(rw_o[i]),    32'(st[i][2].wr));
        check_val("wd_sel_w",    i, 32'(wd_o[i]),    32'(st[i][2].wd));
        check_val("wa_w",        i, 32'(wa_o[i]),    32'(st[i][2].wa));
        check_val("fwd_rs_d",    i, 32'(frs_d_o[i]), 32'(fd[0]));
        check_val("fwd_rt_d",    i, 32'(frt_d_o[i]), 32'(fd[1]));
        check_val("fwd_rs_e",    i, 32'(frs_e_o[i]), 32'(fe[0]));
        check_val("fwd_rt_e",    i, 32'(frt_e_o[i]), 32'(fe[1]));
        check_val("fwd_rt_m",    i, 32'(frt_m_o[i]), 32'(fm));
        dec = d;
    endtask

    function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt, input int rd);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic int rnd_reg();
        int v;
        v = $urandom_range(0, 4);
        return (v == 4) ? 31 : v;
    endfunction

    function automatic logic [31:0] rnd_instr();
        int c;
        c = $urandom_range(0, 10);
        case (c)
            0:       return enc_r(33, rnd_reg(), rnd_reg(), rnd_reg());
            1:       return enc_r(35, rnd_reg(), rnd_reg(), rnd_reg());
            2:       return enc_r(8, rnd_reg(), 0, 0);
            3:       return enc_i(13, rnd_reg(), rnd_reg(), $urandom_range(0, 65535));
            4:       return enc_i(15, rnd_reg(), rnd_reg(), $urandom_range(0, 65535));
            5:       return enc_i(35, rnd_reg(), rnd_reg(), 4);
            6:       return enc_i(43, rnd_reg(), rnd_reg(), 8);
            7:       return enc_i(4, rnd_reg(), rnd_reg(), 3);
            8:       return {6'd2, 26'($urandom)};
            9:       return {6'd3, 26'($urandom)};
            default: return 32'($urandom);
        endcase
    endfunction

    logic [31:0] prog [$];
    int          pc   [2];
    bit          stl  [2];
    ins_t        dec  [2];
    int          cyc;

    initial begin
        nop_i = '{default: 0};
        // Directed sequences first, then random traffic.
        prog.push_back(enc_r(33, 1, 2, 3));                       // addu $3,$1,$2
        prog.push_back(32'd0); prog.push_back(32'd0); prog.push_back(32'd0);
        prog.push_back(enc_r(33, 2, 3, 1));                       // addu $1,$2,$3
        prog.push_back(enc_r(33, 1, 1, 4));                       // addu $4,$1,$1
        prog.push_back(32'd0); prog.push_back(32'd0);
        prog.push_back(enc_i(35, 0, 2, 0));                       // lw $2,0($0)
        prog.push_back(enc_r(33, 2, 0, 5));                       // addu $5,$2,$0
        prog.push_back(32'd0); prog.push_back(32'd0);
        prog.push_back(enc_r(33, 2, 3, 1));                       // addu $1,$2,$3
        prog.push_back(enc_i(4, 1, 1, 4));                        // beq $1,$1
        prog.push_back(32'd0); prog.push_back(32'd0);
        prog.push_back({6'd3, 26'd100});                          // jal
        prog.push_back(32'd0);                                    // delay slot
        prog.push_back(enc_r(8, 31, 0, 0));                       // jr $31
        prog.push_back(32'd0); prog.push_back(32'd0);
        prog.push_back(enc_r(33, 2, 3, 1));                       // addu $1,$2,$3
        prog.push_back(enc_i(13, 1, 6, 1));                       // ori $6,$1,1
        prog.push_back(enc_i(43, 0, 6, 0));                       // sw $6,0($0)
        prog.push_back(32'd0); prog.push_back(32'd0); prog.push_back(32'd0);
        for (int n = 0; n < 300; n++) prog.push_back(rnd_instr());

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instr_v[i] = 32'd0; cmp_v[i] = 1'b0; pc[i] = 0;
            for (int k = 0; k < 3; k++) st[i][k] = nop_i;
        end
        repeat (2) @(posedge clk);
        #1;
        cyc = 0;
        while ((pc[0] < prog.size() || pc[1] < prog.size()) && cyc < 5000) begin
            reset = (cyc < 2) || (cyc >= 60 && $urandom_range(0, 39) == 0);
            for (int i = 0; i < 2; i++) begin
                instr_v[i] = (pc[i] < prog.size()) ? prog[pc[i]] : 32'd0;
                cmp_v[i]   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) model_cycle(i, stl[i], dec[i]);
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    for (int k = 0; k < 3; k++) st[i][k] = nop_i;
                end else begin
                    st[i][2] = st[i][1];
                    st[i][1] = st[i][0];
                    st[i][0] = stl[i] ? nop_i : dec[i];
                    if (!stl[i]) pc[i]++;
                end
            end
            cyc++;
        end
        check_val("prog_done", 0, 32'(pc[0] >= prog.size() && pc[1] >= prog.size()), 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
